// File: rtl/ddc_accum_pkg.sv
// Shared defaults and FSM encoding for the DDC I/Q window accumulator.
package ddc_accum_pkg;

    localparam int DEF_DIN_WIDTH = 32;
    localparam int DEF_LEN_WIDTH = 16;
    localparam int DEF_ACC_WIDTH = DEF_DIN_WIDTH + DEF_LEN_WIDTH;
    localparam int TUSER_WIDTH   = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/ddc_accum_lane.sv
// Single signed accumulator lane: clear, load (start of window) or add one sample.
module ddc_accum_lane
    import ddc_accum_pkg::*;
#(
    parameter int DIN_WIDTH = DEF_DIN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clr,
    input  logic                        i_load,
    input  logic                        i_add,
    input  logic signed [DIN_WIDTH-1:0] i_din,
    output logic signed [ACC_WIDTH-1:0] o_sum
);

    function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [DIN_WIDTH-1:0] d);
        return {{(ACC_WIDTH-DIN_WIDTH){d[DIN_WIDTH-1]}}, d};
    endfunction

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_ext;

    assign w_ext = sext(i_din);
    // Running total including the current sample; this is the window result on close.
    assign o_sum = r_acc + w_ext;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= w_ext;
        end else if (i_add) begin
            r_acc <= o_sum;
        end
    end

endmodule

// File: rtl/ddc_accum.sv
// Integrates DDC I/Q samples over windows of accum_len+1 valid samples and
// presents each window sum on an AXI-Stream output with a sequence number.
module ddc_accum
    import ddc_accum_pkg::*;
#(
    parameter int DIN_WIDTH = DEF_DIN_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int ACC_WIDTH = DIN_WIDTH + LEN_WIDTH
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_aresetn,
    input  logic [2*DIN_WIDTH-1:0]   s_axis_ddc_tdata,
    input  logic                     s_axis_ddc_tvalid,
    input  logic [LEN_WIDTH-1:0]     accum_len,
    input  logic                     resync,
    output logic [2*ACC_WIDTH-1:0]   m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                     overflow
);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [LEN_WIDTH-1:0]        r_len;
    logic [LEN_WIDTH-1:0]        r_cnt;
    logic [TUSER_WIDTH-1:0]      r_seq;
    logic                        w_clr;
    logic                        w_load;
    logic                        w_add;
    logic                        w_close;
    logic                        w_take;
    logic signed [DIN_WIDTH-1:0] w_din_i;
    logic signed [DIN_WIDTH-1:0] w_din_q;
    logic signed [ACC_WIDTH-1:0] w_sum_i;
    logic signed [ACC_WIDTH-1:0] w_sum_q;
    logic [2*ACC_WIDTH-1:0]      r_tdata_p1;
    logic [TUSER_WIDTH-1:0]      r_tuser_p1;
    logic                        r_vld_p1;
    logic                        r_ovf;

    assign w_din_i = s_axis_ddc_tdata[DIN_WIDTH-1:0];
    assign w_din_q = s_axis_ddc_tdata[2*DIN_WIDTH-1:DIN_WIDTH];

    ddc_accum_lane #(.DIN_WIDTH(DIN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_i (
        .i_clk   (s_axis_aclk),
        .i_rst_n (s_axis_aresetn),
        .i_clr   (w_clr),
        .i_load  (w_load),
        .i_add   (w_add),
        .i_din   (w_din_i),
        .o_sum   (w_sum_i)
    );

    ddc_accum_lane #(.DIN_WIDTH(DIN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_q (
        .i_clk   (s_axis_aclk),
        .i_rst_n (s_axis_aresetn),
        .i_clr   (w_clr),
        .i_load  (w_load),
        .i_add   (w_add),
        .i_din   (w_din_q),
        .o_sum   (w_sum_q)
    );

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (resync) begin
            w_state_nxt = ST_IDLE;
        end else if (r_state == ST_IDLE && s_axis_ddc_tvalid) begin
            w_state_nxt = ST_ACCUM;
        end
    end

    // The sample count register holds how many samples are already in the
    // window, so the incoming sample closes the window when it equals the length.
    always_comb begin
        w_clr   = 1'b0;
        w_load  = 1'b0;
        w_add   = 1'b0;
        w_close = 1'b0;
        if (resync) begin
            w_clr = 1'b1;
        end else if (s_axis_ddc_tvalid) begin
            case (r_state)
                ST_IDLE: begin
                    if (accum_len == '0) begin
                        w_close = 1'b1;
                        w_clr   = 1'b1;
                    end else begin
                        w_load  = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (r_cnt == r_len) begin
                        w_close = 1'b1;
                        w_clr   = 1'b1;
                    end else begin
                        w_add   = 1'b1;
                    end
                end
                default: begin
                    w_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_cnt <= '0;
            r_len <= '0;
        end else begin
            if (w_clr) begin
                r_cnt <= '0;
            end else if (w_load) begin
                r_cnt <= LEN_WIDTH'(1);
            end else if (w_add) begin
                r_cnt <= r_cnt + LEN_WIDTH'(1);
            end
            // Length is captured only at window start so mid-window changes wait.
            if (!resync && s_axis_ddc_tvalid && (r_state == ST_IDLE || w_close)) begin
                r_len <= accum_len;
            end
        end
    end

    // ---- output stage (p1): one-deep result register, drop-on-full ----
    assign w_take = w_close && (!r_vld_p1 || m_axis_tready);

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_seq <= '0;
            r_ovf <= 1'b0;
        end else if (resync) begin
            r_seq <= '0;
            r_ovf <= 1'b0;
        end else if (w_close) begin
            r_seq <= r_seq + TUSER_WIDTH'(1);
            if (!w_take) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_tdata_p1 <= '0;
            r_tuser_p1 <= '0;
            r_vld_p1   <= 1'b0;
        end else if (w_take) begin
            r_tdata_p1 <= {w_sum_q, w_sum_i};
            r_tuser_p1 <= r_seq;
            r_vld_p1   <= 1'b1;
        end else if (m_axis_tready) begin
            r_vld_p1   <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_tdata_p1;
    assign m_axis_tuser  = r_tuser_p1;
    assign m_axis_tvalid = r_vld_p1;
    assign overflow      = r_ovf;

endmodule

// File: tb/tb_ddc_accum.sv
// Randomized and directed bench for ddc_accum with a queue-based scoreboard.
module tb_ddc_accum;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int AW = 48;

    logic          clk = 1'b0;
    logic          rstn;
    logic [63:0]   din;
    logic          dv;
    logic [15:0]   alen;
    logic          rs;
    logic [95:0]   mdata;
    logic          mvalid;
    logic          mready;
    logic [15:0]   muser;
    logic          ovf;

    always #5 clk = ~clk;

    ddc_accum #(.DIN_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) dut (
        .s_axis_aclk       (clk),
        .s_axis_aresetn    (rstn),
        .s_axis_ddc_tdata  (din),
        .s_axis_ddc_tvalid (dv),
        .accum_len         (alen),
        .resync            (rs),
        .m_axis_tdata      (mdata),
        .m_axis_tvalid     (mvalid),
        .m_axis_tready     (mready),
        .m_axis_tuser      (muser),
        .overflow          (ovf)
    );

    typedef struct packed {
        logic [95:0] data;
        logic [15:0] user;
    } word_t;

    word_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: window as a running sample count and plain integer sums.
    bit          m_idle = 1'b1;
    bit          m_full = 1'b0;
    bit          m_ovf  = 1'b0;
    bit          exp_ovf = 1'b0;
    longint      m_si = 0;
    longint      m_sq = 0;
    int          m_cnt = 0;
    int          m_len = 0;
    logic [15:0] m_seq = '0;
    bit          in_reset = 1'b1;

    logic [95:0] last_data = '0;
    logic [15:0] last_user = '0;
    int          xfer_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic void model_step(input bit v, input logic signed [31:0] si,
                                       input logic signed [31:0] sq, input bit rdy,
                                       input bit r, input int len_in);
        bit    hs;
        bit    nr;
        word_t w;
        hs = m_full && rdy;
        nr = 1'b0;
        w  = '0;
        if (r) begin
            m_idle = 1'b1; m_cnt = 0; m_si = 0; m_sq = 0; m_seq = '0; m_ovf = 1'b0;
        end else if (v) begin
            if (m_idle) begin
                m_len  = len_in;
                m_idle = 1'b0;
            end
            m_si += longint'(si);
            m_sq += longint'(sq);
            m_cnt++;
            if (m_cnt == m_len + 1) begin
                nr     = 1'b1;
                w.data = {m_sq[47:0], m_si[47:0]};
                w.user = m_seq;
                m_seq  = m_seq + 16'd1;
                m_cnt  = 0; m_si = 0; m_sq = 0;
                m_len  = len_in;
            end
        end
        if (nr) begin
            if (!m_full || rdy) begin
                exp_q.push_back(w);
                m_full = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (hs) begin
            m_full = 1'b0;
        end
    endfunction

    task automatic step(input bit v, input logic [31:0] i, input logic [31:0] q,
                        input bit rdy, input bit r);
        dv = v; din = {q, i}; mready = rdy; rs = r;
        model_step(v, i, q, rdy, r, int'(alen));
        @(posedge clk);
        #1;
        exp_ovf = m_ovf;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        dv = 1'b0; rs = 1'b0; mready = 1'b0; din = '0; rstn = 1'b0; in_reset = 1'b1;
        exp_q.delete();
        m_idle = 1'b1; m_full = 1'b0; m_ovf = 1'b0; exp_ovf = 1'b0;
        m_cnt = 0; m_si = 0; m_sq = 0; m_seq = '0; m_len = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tvalid", mvalid, 0);
        check("reset_tdata", mdata, 0);
        check("reset_tuser", muser, 0);
        check("reset_overflow", ovf, 0);
        rstn = 1'b1;
        in_reset = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        word_t w;
        if (!in_reset) begin
            check("overflow", ovf, exp_ovf);
            if (mvalid && mready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data %h user %0d, required no output", mdata, muser);
                end else begin
                    w = exp_q.pop_front();
                    check("tdata", mdata, w.data);
                    check("tuser", muser, w.user);
                end
                last_data = mdata;
                last_user = muser;
                xfer_cnt++;
            end
        end
    end

    initial begin
        int xs;
        int tot;
        alen = '0;
        do_reset();

        // Continuous I=1, Q=-1 over 4-sample windows
        alen = 16'd3;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        xs = xfer_cnt;
        repeat (16) step(1'b1, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle(2);
        check("len3_count", xfer_cnt - xs, 4);
        check("len3_data", last_data, {48'hFFFF_FFFF_FFFC, 48'h0000_0000_0004});
        check("len3_user", last_user, 3);

        // Single-sample windows at full scale
        alen = 16'd0;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        xs = xfer_cnt;
        repeat (4) step(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        idle(2);
        check("len0_count", xfer_cnt - xs, 4);
        check("len0_data", last_data, {48'hFFFF_8000_0000, 48'h0000_7FFF_FFFF});
        check("len0_user", last_user, 3);

        // Output held off: second result dropped, third replaces on handshake
        alen = 16'd1;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        xs = xfer_cnt;
        for (int s = 1; s <= 5; s++) step(1'b1, 32'(s), 32'(-s), 1'b0, 1'b0);
        check("ovf_set", ovf, 1);
        check("ovf_hold_user", muser, 0);
        step(1'b1, 32'd6, 32'(-6), 1'b1, 1'b0);
        idle(2);
        check("ovf_count", xfer_cnt - xs, 2);
        check("ovf_data", last_data, {48'hFFFF_FFFF_FFF5, 48'h0000_0000_000B});
        check("ovf_user", last_user, 2);
        check("ovf_sticky", ovf, 1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        check("ovf_cleared_by_resync", ovf, 0);

        // Resync mid-window discards the partial window and its own sample
        alen = 16'd7;
        xs = xfer_cnt;
        repeat (3) step(1'b1, 32'd1, 32'd1, 1'b1, 1'b0);
        step(1'b1, 32'd100, 32'd100, 1'b1, 1'b1);
        for (int s = 10; s <= 17; s++) step(1'b1, 32'(s), 32'(-s), 1'b1, 1'b0);
        idle(2);
        check("resync_count", xfer_cnt - xs, 1);
        check("resync_data", last_data, {48'hFFFF_FFFF_FF94, 48'h0000_0000_006C});
        check("resync_user", last_user, 0);

        // Gapped input: latency is one cycle after the last valid sample
        alen = 16'd3;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        for (int s = 1; s <= 3; s++) begin
            step(1'b1, 32'(s), 32'(2 * s), 1'b1, 1'b0);
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        check("gap_not_early", mvalid, 0);
        step(1'b1, 32'd4, 32'd8, 1'b1, 1'b0);
        check("gap_latency_valid", mvalid, 1);
        check("gap_data", mdata, {48'd20, 48'd10});
        idle(2);

        // Length change mid-window takes effect only from the next window
        alen = 16'd3;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        xs = xfer_cnt;
        step(1'b1, 32'd1, 32'd0, 1'b1, 1'b0);
        alen = 16'd0;
        for (int s = 2; s <= 5; s++) step(1'b1, 32'(s), 32'd0, 1'b1, 1'b0);
        idle(2);
        check("lenchg_count", xfer_cnt - xs, 2);
        check("lenchg_last", last_data, {48'd0, 48'd5});

        // Reset mid-window discards the partial sum
        alen = 16'd3;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        repeat (2) step(1'b1, 32'd50, 32'd50, 1'b1, 1'b0);
        do_reset();
        xs = xfer_cnt;
        for (int s = 1; s <= 4; s++) step(1'b1, 32'(s), 32'd0, 1'b1, 1'b0);
        idle(2);
        check("rstmid_count", xfer_cnt - xs, 1);
        check("rstmid_data", last_data, {48'd0, 48'd10});
        check("rstmid_user", last_user, 0);

        // Randomized traffic: lengths, gaps, backpressure, occasional resync
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) alen = 16'($urandom_range(0, 5));
            step(($urandom_range(0, 3) != 0), $urandom, $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end
        idle(3);

        // Longest window at negative full scale must not wrap
        alen = 16'hFFFF;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        xs = xfer_cnt;
        tot = 65536;
        repeat (tot) step(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        idle(2);
        check("maxlen_count", xfer_cnt - xs, 1);
        check("maxlen_data", last_data, {48'h7FFF_FFFF_0000, 48'h8000_0000_0000});

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
